// File: rtl/barrel_unshift_pipe_if.sv
// Handshake bundle for the de-rotator: input vector stream in, natural-order stream out.
// master drives the input side and consumes the output side; slave is the de-rotator itself.
interface barrel_unshift_pipe_if #(
    parameter int WIDTH = 360,
    parameter int SHW   = 9,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic             in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_wrap;

    modport master (
        output in_valid, in_data, in_shift, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_wrap
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_wrap
    );
endinterface

// File: rtl/barrel_unshift_pipe.sv
// Pipelined circular left-rotator undoing an encoder right rotation; SHW cycles latency.
// Global stall: all stages hold while out_valid=1 and out_ready=0; in_ready = ~out_valid | out_ready.
module barrel_unshift_pipe #(
    parameter int WIDTH = 360,
    parameter int SHW   = 9,
    parameter int TAG_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    barrel_unshift_pipe_if.slave bus
);
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic [SHW-1:0]   sh;
        logic [TAG_W-1:0] tag;
        logic             wrap;
    } stage_t;

    stage_t src   [SHW];
    stage_t stg_d [SHW];
    stage_t stg_q [SHW];
    logic   adv;

    // r may be 0 when 2^k is a multiple of WIDTH; d >> WIDTH then yields zero and d passes through.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d, input int r);
        return (d << r) | (d >> (WIDTH - r));
    endfunction

    assign adv = ~stg_q[SHW-1].vld | bus.out_ready;

    always_comb begin
        src[0].vld  = bus.in_valid;
        src[0].dat  = bus.in_data;
        src[0].sh   = bus.in_shift & {SHW{bus.in_sel}};
        src[0].tag  = bus.in_tag;
        src[0].wrap = (int'(bus.in_shift) >= WIDTH);
        for (int k = 1; k < SHW; k++) begin
            src[k] = stg_q[k-1];
        end
        // Stage k owns shift bit k; the full shift word rides along so later stages see their bit.
        for (int k = 0; k < SHW; k++) begin
            stg_d[k] = src[k];
            if (src[k].sh[k]) begin
                stg_d[k].dat = rotl(src[k].dat, (1 << k) % WIDTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                stg_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < SHW; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = stg_q[SHW-1].vld;
    assign bus.out_data  = stg_q[SHW-1].dat;
    assign bus.out_tag   = stg_q[SHW-1].tag;
    assign bus.out_wrap  = stg_q[SHW-1].wrap;
endmodule

// File: tb/tb_barrel_unshift_pipe.sv
// Randomised bench for barrel_unshift_pipe: bit-index rotation model plus scoreboard,
// with literal pins for single-bit, bypass and wrap cases.
module tb_barrel_unshift_pipe;
    localparam int WIDTH = 360;
    localparam int SHW   = 9;
    localparam int TAG_W = 8;

    typedef logic [WIDTH-1:0] vec_t;
    typedef struct {
        vec_t             dat;
        logic [TAG_W-1:0] tag;
        logic             wrap;
        int               cyc;
        bit               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rnd_bit = 1'b1;
    int   rdy_mode = 0;
    bit   lat_chk = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_out = 0;
    exp_t exp_q[$];

    bit               held_v = 1'b0;
    vec_t             held_d;
    logic [TAG_W-1:0] held_t;
    logic             held_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom());
    end

    barrel_unshift_pipe_if #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) bus ();

    assign bus.out_ready = (rdy_mode == 0) ? 1'b1 : rnd_bit;

    barrel_unshift_pipe #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk_v(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Left rotation straight from the index rule: out[i] = in[(i - s) mod WIDTH].
    function automatic vec_t model_rot(input vec_t d, input int s);
        vec_t r;
        int   m;
        m = s % WIDTH;
        for (int i = 0; i < WIDTH; i++) r[i] = d[(i - m + WIDTH) % WIDTH];
        return r;
    endfunction

    // Encoder-side right rotation, used to build inverse-check stimulus.
    function automatic vec_t enc_rotr(input vec_t d, input int s);
        vec_t r;
        for (int i = 0; i < WIDTH; i++) r[i] = d[(i + s) % WIDTH];
        return r;
    endfunction

    function automatic vec_t onehot(input int k);
        vec_t v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < WIDTH; i++) v[i] = 1'($urandom());
        return v;
    endfunction

    function automatic int popcnt(input vec_t v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            chk_i("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            if (held_v) begin
                chk_i("stall_valid", int'(bus.out_valid), 1);
                chk_v("stall_data", bus.out_data, held_d);
                chk_i("stall_tag", int'(bus.out_tag), int'(held_t));
                chk_i("stall_wrap", int'(bus.out_wrap), int'(held_w));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: tag %0d emitted with nothing outstanding", bus.out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk_v("out_data", bus.out_data, e.dat);
                    chk_i("out_tag", int'(bus.out_tag), int'(e.tag));
                    chk_i("out_wrap", int'(bus.out_wrap), int'(e.wrap));
                    if (e.lat) chk_i("latency", cyc - e.cyc, SHW);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.dat  = bus.in_sel ? model_rot(bus.in_data, int'(bus.in_shift)) : bus.in_data;
                e.tag  = bus.in_tag;
                e.wrap = (int'(bus.in_shift) >= WIDTH);
                e.cyc  = cyc;
                e.lat  = lat_chk;
                exp_q.push_back(e);
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            held_t = bus.out_tag;
            held_w = bus.out_wrap;
        end
    end

    task automatic send(input vec_t d, input int sh, input logic sel, input int tag);
        bit ok;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shift = SHW'(sh);
        bus.in_sel   = sel;
        bus.in_tag   = TAG_W'(tag);
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 1000);
        if (!ok) chk_i("send_timeout", int'(ok), 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output vec_t d, output int w);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        d = '0;
        w = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                ok = 1'b1;
                d = bus.out_data;
                w = int'(bus.out_wrap);
            end
            n++;
        end
        if (!ok) chk_i("wait_out_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 2000) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !bus.out_valid;
            n++;
        end
        if (!ok) chk_i("drain_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input vec_t d, input int sh, input logic sel,
                       input vec_t exp_d, input int exp_w);
        vec_t got;
        int   w;
        send(d, sh, sel, 0);
        wait_out(got, w);
        chk_v(name, got, exp_d);
        chk_i({name, "_wrap"}, w, exp_w);
    endtask

    initial begin
        vec_t v, v2;
        int   sh, run, n, base;
        bit   seen;

        if ((1 << SHW) < WIDTH) begin
            $display("FAIL param_check: 2^SHW=%0d below WIDTH=%0d", 1 << SHW, WIDTH);
            $fatal(1, "shift width too small");
        end

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_shift = '0;
        bus.in_sel   = 1'b0;
        bus.in_tag   = '0;

        // Reset state, with a valid input present that must be discarded.
        bus.in_valid = 1'b1;
        bus.in_data  = rand_vec();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("reset_out_valid", int'(bus.out_valid), 0);
        chk_v("reset_out_data", bus.out_data, '0);
        chk_i("reset_out_tag", int'(bus.out_tag), 0);
        chk_i("reset_out_wrap", int'(bus.out_wrap), 0);
        chk_i("reset_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Model pins.
        v = rand_vec();
        chk_v("model_inverse_180", model_rot(enc_rotr(v, 180), 180), v);
        chk_v("model_onehot_1", model_rot(onehot(0), 1), onehot(1));

        // Literal expectations through the DUT.
        pin("bit0_shift1", onehot(0), 1, 1'b1, onehot(1), 0);
        pin("bit0_shift359", onehot(0), 359, 1'b1, onehot(359), 0);
        pin("bypass_77", v, 77, 1'b0, v, 0);
        pin("wrap_400", onehot(0), 400, 1'b1, onehot(40), 1);
        pin("wrap_511", onehot(0), 511, 1'b1, onehot(151), 1);
        pin("bit5_shift356", onehot(5), 356, 1'b1, onehot(1), 0);
        wait_empty();

        // Inverse stream: encoder rotation undone, back-to-back.
        for (int i = 0; i < 105; i++) begin
            case (i)
                0: sh = 180;
                1: sh = 0;
                2: sh = 1;
                3: sh = 179;
                4: sh = 359;
                default: sh = $urandom_range(WIDTH - 1, 0);
            endcase
            v = rand_vec();
            v2 = enc_rotr(v, sh);
            if (i < 5) chk_i("popcount_conserved", popcnt(model_rot(v2, sh)), popcnt(v));
            send(v2, sh, 1'b1, i);
        end
        wait_empty();

        // Backpressure: random out_ready, random shifts/selects, tags 0..31.
        rdy_mode = 1;
        lat_chk = 1'b0;
        base = n_out;
        for (int t = 0; t < 32; t++) begin
            send(rand_vec(), $urandom_range((1 << SHW) - 1, 0), 1'($urandom()), t);
        end
        wait_empty();
        chk_i("bp_item_count", n_out - base, 32);
        rdy_mode = 0;
        lat_chk = 1'b1;

        // Full throughput: 64 items, expect one unbroken run of 64 valid cycles.
        run = 0;
        fork
            begin
                for (int t = 0; t < 64; t++) begin
                    send(rand_vec(), $urandom_range((1 << SHW) - 1, 0), 1'b1, t + 64);
                end
            end
            begin
                seen = 1'b0;
                n = 0;
                while (!seen && n < 50) begin
                    @(negedge clk);
                    seen = bus.out_valid;
                    n++;
                end
                while (bus.out_valid && run < 200) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        chk_i("throughput_run", run, 64);
        wait_empty();

        // Reset with 5 items in flight.
        for (int t = 0; t < 5; t++) send(rand_vec(), $urandom_range(WIDTH - 1, 0), 1'b1, 200 + t);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = rand_vec();
        bus.in_tag   = 8'd250;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_i("midreset_out_valid", int'(bus.out_valid), 0);
        chk_v("midreset_out_data", bus.out_data, '0);
        base = n_out;
        repeat (15) @(posedge clk);
        #1;
        chk_i("midreset_no_stale", n_out - base, 0);
        v = rand_vec();
        send(v, 123, 1'b1, 7);
        wait_empty();
        chk_i("post_reset_count", n_out - base, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
